// File: rtl/simd_lane_unpack.sv
// Return-path unpacker: buffers packed 48-bit SIMD results and emits one lane per cycle
// with lane index, last-lane marker and per-lane carry-out.
module simd_lane_unpack #(
  parameter int DEPTH    = 2,
  parameter bit SIGN_EXT = 1'b0
) (
  input  logic        ap_clk,
  input  logic        ap_rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [47:0] in_data,
  input  logic        in_mode,
  input  logic [3:0]  in_carry,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [23:0] out_data,
  output logic [1:0]  out_lane,
  output logic        out_last,
  output logic        out_ovf,
  output logic        busy
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  typedef enum logic {S_IDLE, S_EMIT} state_t;

  logic [52:0]   mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q, count_d;
  logic          in_ready_q;
  logic          push, pop, fifo_nempty;

  state_t        state_q, state_d;
  logic [1:0]    lane_q, lane_d;
  logic [47:0]   word_data_q;
  logic          word_mode_q;
  logic [3:0]    word_carry_q;
  logic          is_last, emit;
  logic [11:0]   seg12;
  logic [23:0]   lane_val;
  logic          lane_ovf;

  assign push        = in_valid & in_ready_q;
  assign fifo_nempty = (count_q != '0);

  always_comb begin
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge ap_clk) begin
    if (push) mem_q[wr_ptr_q] <= {in_data, in_mode, in_carry};
  end

  // in_ready is a registered view of the post-edge occupancy
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      in_ready_q <= 1'b0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q    <= count_d;
      in_ready_q <= (count_d < DEPTH_C);
    end
  end

  assign is_last = (lane_q == (word_mode_q ? 2'd1 : 2'd3));
  assign emit    = (state_q == S_EMIT);

  always_comb begin
    state_d = state_q;
    lane_d  = lane_q;
    pop     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (fifo_nempty) begin
          pop     = 1'b1;
          lane_d  = 2'd0;
          state_d = S_EMIT;
        end
      end
      S_EMIT: begin
        if (out_ready) begin
          if (is_last) begin
            lane_d = 2'd0;
            if (fifo_nempty) pop = 1'b1;
            else             state_d = S_IDLE;
          end else begin
            lane_d = lane_q + 2'd1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      state_q      <= S_IDLE;
      lane_q       <= 2'd0;
      word_data_q  <= '0;
      word_mode_q  <= 1'b0;
      word_carry_q <= '0;
    end else begin
      state_q <= state_d;
      lane_q  <= lane_d;
      if (pop) {word_data_q, word_mode_q, word_carry_q} <= mem_q[rd_ptr_q];
    end
  end

  always_comb begin
    seg12    = 12'h000;
    lane_val = 24'h000000;
    lane_ovf = 1'b0;
    if (word_mode_q) begin
      lane_val = lane_q[0] ? word_data_q[47:24] : word_data_q[23:0];
      lane_ovf = lane_q[0] ? word_carry_q[3] : word_carry_q[1];
    end else begin
      case (lane_q)
        2'd0:    seg12 = word_data_q[11:0];
        2'd1:    seg12 = word_data_q[23:12];
        2'd2:    seg12 = word_data_q[35:24];
        default: seg12 = word_data_q[47:36];
      endcase
      lane_val = {{12{SIGN_EXT & seg12[11]}}, seg12};
      lane_ovf = word_carry_q[lane_q];
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = emit;
  assign out_data  = emit ? lane_val : 24'h000000;
  assign out_lane  = emit ? lane_q : 2'd0;
  assign out_last  = emit & is_last;
  assign out_ovf   = emit & lane_ovf;
  assign busy      = fifo_nempty | emit;

endmodule

// File: tb/tb_simd_lane_unpack.sv
// Directed self-checking bench for simd_lane_unpack (DEPTH=2, SIGN_EXT=1).
module tb_simd_lane_unpack;

  logic        ap_clk = 1'b0;
  logic        ap_rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [47:0] in_data;
  logic        in_mode;
  logic [3:0]  in_carry;
  logic        out_valid;
  logic        out_ready;
  logic [23:0] out_data;
  logic [1:0]  out_lane;
  logic        out_last;
  logic        out_ovf;
  logic        busy;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [23:0] d;
    logic [1:0]  l;
    logic        last;
    logic        ovf;
  } lane_t;

  typedef struct {
    logic [47:0] d;
    logic        m;
    logic [3:0]  c;
  } word_t;

  lane_t exp_q[$];
  word_t word_q[$];
  bit    saw_full;

  simd_lane_unpack #(.DEPTH(2), .SIGN_EXT(1'b1)) dut (
    .ap_clk   (ap_clk),
    .ap_rst_n (ap_rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .in_mode  (in_mode),
    .in_carry (in_carry),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .out_lane (out_lane),
    .out_last (out_last),
    .out_ovf  (out_ovf),
    .busy     (busy)
  );

  always #5 ap_clk = ~ap_clk;

  task automatic check_eq(input string tag, input logic [47:0] obs, input logic [47:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge ap_clk);
    #1;
  endtask

  task automatic add_exp(input logic [23:0] d, input logic [1:0] l, input logic last, input logic ovf);
    lane_t e;
    e.d = d; e.l = l; e.last = last; e.ovf = ovf;
    exp_q.push_back(e);
  endtask

  task automatic add_word(input logic [47:0] d, input logic m, input logic [3:0] c);
    word_t w;
    w.d = d; w.m = m; w.c = c;
    word_q.push_back(w);
  endtask

  // Holds in_valid until the word is taken on an edge where in_ready was high
  task automatic push_word(input logic [47:0] d, input logic m, input logic [3:0] c);
    bit taken;
    taken    = 1'b0;
    in_valid = 1'b1;
    in_data  = d;
    in_mode  = m;
    in_carry = c;
    for (int i = 0; i < 200 && !taken; i++) begin
      taken = in_ready;
      tick();
    end
    in_valid = 1'b0;
    in_data  = 48'h0;
    if (!taken) check_eq("push_timeout", 0, 1);
  endtask

  task automatic push_all();
    while (word_q.size() > 0) begin
      word_t w;
      w = word_q.pop_front();
      push_word(w.d, w.m, w.c);
    end
  endtask

  task automatic consume(input bit toggle, input bit nogap);
    bit    started;
    int    cyc;
    lane_t e;
    started = 1'b0;
    cyc     = 0;
    while (exp_q.size() > 0 && cyc < 400) begin
      out_ready = toggle ? ((cyc % 2) == 0) : 1'b1;
      if (!in_ready) saw_full = 1'b1;
      if (out_valid) begin
        started = 1'b1;
        e = exp_q[0];
        check_eq("out_data", out_data, e.d);
        check_eq("out_lane", out_lane, e.l);
        check_eq("out_last", out_last, e.last);
        check_eq("out_ovf",  out_ovf,  e.ovf);
        if (out_ready) void'(exp_q.pop_front());
      end else if (started && nogap) begin
        check_eq("no_gap", out_valid, 1);
      end
      tick();
      cyc++;
    end
    out_ready = 1'b0;
    if (exp_q.size() != 0) begin
      check_eq("consume_timeout", exp_q.size(), 0);
      exp_q.delete();
    end
  endtask

  initial begin
    ap_rst_n  = 1'b0;
    in_valid  = 1'b0;
    in_data   = 48'h0;
    in_mode   = 1'b0;
    in_carry  = 4'h0;
    out_ready = 1'b0;
    saw_full  = 1'b0;

    #3;
    check_eq("rst_in_ready", in_ready, 0);
    check_eq("rst_out_valid", out_valid, 0);
    check_eq("rst_out_data", out_data, 0);
    check_eq("rst_busy", busy, 0);
    #19;
    ap_rst_n = 1'b1;
    #1;
    check_eq("rel_in_ready_pre", in_ready, 0);
    tick();
    check_eq("rel_in_ready", in_ready, 1);

    // four12 single word, sign-extended
    push_word(48'h003_002_001_FFF, 1'b0, 4'b0001);
    check_eq("lat_edge_n", out_valid, 0);
    tick();
    check_eq("lat_edge_n1", out_valid, 1);
    add_exp(24'hFFFFFF, 2'd0, 1'b0, 1'b1);
    add_exp(24'h000001, 2'd1, 1'b0, 1'b0);
    add_exp(24'h000002, 2'd2, 1'b0, 1'b0);
    add_exp(24'h000003, 2'd3, 1'b1, 1'b0);
    consume(1'b0, 1'b1);
    check_eq("t1_idle_busy", busy, 0);

    // two24 single word
    push_word(48'h123456_ABCDEF, 1'b1, 4'b1000);
    check_eq("t2_lat_edge_n", out_valid, 0);
    tick();
    add_exp(24'hABCDEF, 2'd0, 1'b0, 1'b0);
    add_exp(24'h123456, 2'd1, 1'b1, 1'b1);
    consume(1'b0, 1'b1);

    // back-to-back mixed modes, no bubbles
    add_word(48'h800_7FF_ABC_123, 1'b0, 4'b1010);
    add_word(48'h800000_7FFFFF,   1'b1, 4'b0010);
    add_word(48'h444_333_222_111, 1'b0, 4'b0100);
    add_exp(24'h000123, 2'd0, 1'b0, 1'b0);
    add_exp(24'hFFFABC, 2'd1, 1'b0, 1'b1);
    add_exp(24'h0007FF, 2'd2, 1'b0, 1'b0);
    add_exp(24'hFFF800, 2'd3, 1'b1, 1'b1);
    add_exp(24'h7FFFFF, 2'd0, 1'b0, 1'b1);
    add_exp(24'h800000, 2'd1, 1'b1, 1'b0);
    add_exp(24'h000111, 2'd0, 1'b0, 1'b0);
    add_exp(24'h000222, 2'd1, 1'b0, 1'b0);
    add_exp(24'h000333, 2'd2, 1'b0, 1'b1);
    add_exp(24'h000444, 2'd3, 1'b1, 1'b0);
    fork
      push_all();
      consume(1'b0, 1'b1);
    join
    check_eq("t3_idle_valid", out_valid, 0);
    check_eq("t3_idle_busy", busy, 0);

    // backpressure with alternating out_ready, five words into a 2-deep buffer
    saw_full = 1'b0;
    add_word(48'h00A_009_008_007, 1'b0, 4'b0000);
    add_word(48'h654321_FEDCBA,   1'b1, 4'b0101);
    add_word(48'h000001_000002,   1'b1, 4'b1010);
    add_word(48'hFFF_000_FFF_000, 1'b0, 4'b1111);
    add_word(48'h0F0_F0F_0F0_F0F, 1'b0, 4'b0110);
    add_exp(24'h000007, 2'd0, 1'b0, 1'b0);
    add_exp(24'h000008, 2'd1, 1'b0, 1'b0);
    add_exp(24'h000009, 2'd2, 1'b0, 1'b0);
    add_exp(24'h00000A, 2'd3, 1'b1, 1'b0);
    add_exp(24'hFEDCBA, 2'd0, 1'b0, 1'b0);
    add_exp(24'h654321, 2'd1, 1'b1, 1'b0);
    add_exp(24'h000002, 2'd0, 1'b0, 1'b1);
    add_exp(24'h000001, 2'd1, 1'b1, 1'b1);
    add_exp(24'h000000, 2'd0, 1'b0, 1'b1);
    add_exp(24'hFFFFFF, 2'd1, 1'b0, 1'b1);
    add_exp(24'h000000, 2'd2, 1'b0, 1'b1);
    add_exp(24'hFFFFFF, 2'd3, 1'b1, 1'b1);
    add_exp(24'hFFFF0F, 2'd0, 1'b0, 1'b0);
    add_exp(24'h0000F0, 2'd1, 1'b0, 1'b1);
    add_exp(24'hFFFF0F, 2'd2, 1'b0, 1'b1);
    add_exp(24'h0000F0, 2'd3, 1'b1, 1'b0);
    fork
      push_all();
      consume(1'b1, 1'b0);
    join
    check_eq("t4_saw_full", saw_full, 1);
    tick();
    check_eq("t4_idle_valid", out_valid, 0);
    check_eq("t4_idle_busy", busy, 0);
    check_eq("t4_in_ready", in_ready, 1);

    // reset during lane 1 with one word still buffered
    push_word(48'h004_003_002_001, 1'b0, 4'b1111);
    push_word(48'h008_007_006_005, 1'b0, 4'b1111);
    check_eq("t5_lane0", out_lane, 0);
    check_eq("t5_valid0", out_valid, 1);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check_eq("t5_lane1", out_lane, 1);
    check_eq("t5_busy_pre", busy, 1);
    #2;
    ap_rst_n = 1'b0;
    #1;
    check_eq("t5_rst_valid", out_valid, 0);
    check_eq("t5_rst_data", out_data, 0);
    check_eq("t5_rst_lane", out_lane, 0);
    check_eq("t5_rst_last", out_last, 0);
    check_eq("t5_rst_ovf", out_ovf, 0);
    check_eq("t5_rst_busy", busy, 0);
    check_eq("t5_rst_in_ready", in_ready, 0);
    tick();
    tick();
    #3;
    ap_rst_n = 1'b1;
    #1;
    check_eq("t5_rel_ready_pre", in_ready, 0);
    tick();
    check_eq("t5_rel_ready", in_ready, 1);
    check_eq("t5_rel_busy", busy, 0);
    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      check_eq("t5_no_stale", out_valid, 0);
      tick();
    end
    out_ready = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/simd_lane_unpack.md
# simd_lane_unpack

Return-path block for the SIMD adder templates: accepts packed 48-bit DSP result words (four12 or two24 mode) over a valid/ready handshake, buffers them, and serializes them into individual lane results, one lane per cycle, with lane index, last-lane marker and per-lane carry-out. It sits between a packed SIMD add unit and scalar consumers that need per-operation results.

## Interface
- DEPTH, 2, input buffer depth in words; power of two, ≥2
- SIGN_EXT, 0, 1 = sign-extend 12-bit lanes to 24 bits; 0 = zero-extend
- ap_clk  in  1  clock; all logic on rising edge
- ap_rst_n  in  1  asynchronous, active-low reset
- in_valid  in  1  packed word present
- in_ready  out  1  buffer can accept a word
- in_data  in  48  packed lane results, lane 0 in LSBs
- in_mode  in  1  0 = four12 (4 lanes × 12 b), 1 = two24 (2 lanes × 24 b)
- in_carry  in  4  per-lane carry-out; four12: bit k = lane k; two24: bit 2k+1 = lane k, even bits ignored
- out_valid  out  1  lane result present
- out_ready  in  1  consumer accepts lane
- out_data  out  24  lane result, extended per SIGN_EXT in four12
- out_lane  out  2  lane index of out_data
- out_last  out  1  final lane of the current word
- out_ovf  out  1  carry-out of the current lane
- busy  out  1  buffer non-empty or serializer holding a word

## Operation
- Input buffer: DEPTH-entry FIFO of {in_data, in_mode, in_carry}; write on in_valid & in_ready.
- Serializer FSM, two states: IDLE (no word loaded), EMIT (word loaded, lane counter L active).
- IDLE -> EMIT when FIFO non-empty: pop head, L = 0.
- EMIT: present lane L; on out_valid & out_ready: if L = last lane (3 in four12, 1 in two24) then pop next word if FIFO non-empty (stay EMIT, L = 0), else -> IDLE; otherwise L = L + 1.
- Lane extraction: four12 lane k = in_data[12k+11:12k], extended to 24 b; two24 lane k = in_data[24k+23:24k]; no arithmetic, bits passed unchanged.
- out_last = 1 exactly when L = last lane for the loaded mode.
- Mode is latched per word; consecutive words may differ in mode.
- busy = (FIFO count ≠ 0) | (state = EMIT).

## Timing
- Reset (async assert): FIFO emptied, state IDLE, L = 0; in_ready, out_valid, out_data, out_lane, out_last, out_ovf, busy all 0.
- in_ready is registered: 0 during reset, 1 on first rising edge after ap_rst_n release; thereafter in_ready = (FIFO count < DEPTH), updated each edge.
- Latency: word accepted at edge N into empty block -> out_valid with lane 0 at edge N+1.
- Throughput: one lane per cycle; no bubble between last lane of a word and lane 0 of the next if FIFO non-empty.
- Simultaneous push and pop with FIFO full: pop frees space on the same edge, but in_ready (registered) still reflects full that cycle; no word is dropped.
- Backpressure: while out_valid & !out_ready, out_data/out_lane/out_last/out_ovf held stable; out_valid never drops without a handshake.
- in_valid must be ignored while in_ready = 0; in_data sampled only on handshake.
- Reset mid-word: remaining lanes and buffered words discarded; no partial output after release.

## Test plan
- four12 single word: in_data = 0x003_002_001_FFF, carry = 4'b0001, SIGN_EXT = 1 -> lanes 0..3 = 0xFFFFFF/ovf1, 0x000001, 0x000002, 0x000003; out_last only on lane 3; lane 0 at edge N+1.
- two24 single word: in_data = 0x123456_ABCDEF, carry = 4'b1000 -> lane 0 = 0xABCDEF ovf0, lane 1 = 0x123456 ovf1 last; SIGN_EXT has no effect.
- Back-to-back mixed modes: four12 then two24 then four12 with out_ready = 1 -> 10 consecutive out_valid cycles, no gap, correct lane indices and out_last.
- Backpressure: out_ready toggled 1010… random; push 5 words, DEPTH = 2 -> in_ready drops when full, no word lost or duplicated, outputs stable while stalled.
- Reset mid-operation: assert ap_rst_n low during lane 1 of a word with 1 word buffered -> all outputs 0 immediately; after release, busy = 0 and no stale lanes emitted; in_ready returns 1 one edge after release.
